// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// serial_rx_pkg : shared types and constants for the 8N1 serial receiver
// Revision 1.0
// ============================================================================
package serial_rx_pkg;

    localparam int c_data_w     = 8;
    localparam int c_sync_depth = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/serial_rx_sync.sv
`default_nettype none
// ============================================================================
// serial_rx_sync : multi-flop synchronizer for the asynchronous RX line
// Revision 1.0
// ============================================================================
module serial_rx_sync
    import serial_rx_pkg::*;
#(
    parameter int DEPTH = c_sync_depth
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    // Resets to the idle-high line level so reset release never fakes a start bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule : serial_rx_sync
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// serial_rx : 8N1 UART receiver, centre-sampled, one-cycle o_wr per byte
// Option: SERIAL_RX_STOP_CHECK_EN discards frames whose stop bit samples 0
// Revision 1.0
// ============================================================================
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx,
    output logic                o_wr,
    output logic [c_data_w-1:0] o_data
);

    localparam int BAUD_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CLKS = BAUD_CLKS / 2;
    localparam int CNT_W     = (BAUD_CLKS < 2) ? 1 : $clog2(BAUD_CLKS);

    localparam logic [CNT_W-1:0] c_half_load = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0] c_baud_load = CNT_W'(BAUD_CLKS - 1);
    localparam logic [2:0]       c_last_bit  = 3'(c_data_w - 1);

    if (BAUD_CLKS < 2) begin : g_baud_check
        $error("serial_rx: CLK_FREQ / BAUD_RATE must be at least 2");
    end

    logic                w_rx_s;
    logic                w_stop_ok;

    rx_state_t           r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_idx;
    logic [c_data_w-1:0] r_shift;
    logic [c_data_w-1:0] r_data;
    logic                r_wr;

    rx_state_t           w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [2:0]          w_idx_nxt;
    logic [c_data_w-1:0] w_shift_nxt;
    logic [c_data_w-1:0] w_data_nxt;
    logic                w_wr_nxt;

    serial_rx_sync #(
        .DEPTH (c_sync_depth)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

`ifdef SERIAL_RX_STOP_CHECK_EN
    assign w_stop_ok = w_rx_s;
`else
    assign w_stop_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_wr_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = c_half_load;
                end
            end

            START: begin
                if (r_cnt == '0) begin
                    // A start bit that is no longer low at its centre was a glitch
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = c_baud_load;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {w_rx_s, r_shift[c_data_w-1:1]};
                    w_cnt_nxt   = c_baud_load;
                    if (r_idx == c_last_bit) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is caught
                if (r_cnt == '0) begin
                    if (w_stop_ok) begin
                        w_data_nxt = r_shift;
                        w_wr_nxt   = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_wr   = r_wr;
    assign o_data = r_data;

endmodule : serial_rx
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// tb_serial_rx : scoreboard bench for serial_rx at 4 clocks per bit
// Revision 1.0
// ============================================================================
module tb_serial_rx;

    localparam int CLK_FREQ  = 500_000;
    localparam int BAUD_RATE = 115_200;
    localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
    // line edge to o_wr edge, plus one because the bench counts from the drive cycle
    localparam int LATENCY   = 2 + BIT_CLKS / 2 + 9 * BIT_CLKS + 1;

`ifdef SERIAL_RX_STOP_CHECK_EN
    localparam bit STOP_CHECK = 1'b1;
`else
    localparam bit STOP_CHECK = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       wr;
    logic [7:0] data;

    longint     cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    logic [7:0] last_data = 8'h00;
    logic       prev_wr = 1'b0;

    serial_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_rx    (rx),
        .o_wr    (wr),
        .o_data  (data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1'b0;
        end else begin
            if (wr && prev_wr) begin
                tests++;
                fails++;
                $display("FAIL wr_double: o_wr high two cycles in a row at cycle %0d", cyc);
            end
            if (wr) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL wr_unexpected: o_wr with data %02h at cycle %0d, none expected", data, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (data !== e.data) begin
                        fails++;
                        $display("FAIL wr_data: got %02h expected %02h", data, e.data);
                    end
                    tests++;
                    if (cyc != e.cyc) begin
                        fails++;
                        $display("FAIL wr_time: got cycle %0d expected cycle %0d", cyc, e.cyc);
                    end
                end
            end
            prev_wr = wr;
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a frame yields its byte LATENCY cycles after its start edge,
    // unless stop checking is enabled and the stop bit was low.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
        exp_t e;
        if (stop_bit || !STOP_CHECK) begin
            e.data = b;
            e.cyc  = cyc + LATENCY;
            sb.push_back(e);
            last_data = b;
        end
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
        hold(stop_bit, BIT_CLKS);
        hold(1'b1, gap);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        check8("reset_wr", {7'd0, wr}, 8'h00);
        check8("reset_data", data, 8'h00);
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 6);

        send_frame(8'h4B, 1'b1, 8);
        check8("single_byte_hold", data, 8'h4B);

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 8);
        check8("back_to_back_hold", data, 8'hFF);

        hold(1'b0, 1);
        hold(1'b1, 10);
        send_frame(8'h3C, 1'b1, 8);

        send_frame(8'h55, 1'b0, 8);
        check8("framing_data", data, last_data);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       sbit;
            int         gap;
            b    = 8'($urandom);
            sbit = ($urandom_range(0, 4) != 0);
            gap  = sbit ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 8));
            send_frame(b, sbit, gap);
        end
        hold(1'b1, 8);
        check8("random_last_data", data, last_data);

        // Abort a frame during data bit 3
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold(1'b1, BIT_CLKS);
        hold(1'b0, 2);
        rst_n = 1'b0;
        #1;
        check8("midreset_wr", {7'd0, wr}, 8'h00);
        check8("midreset_data", data, 8'h00);
        last_data = 8'h00;
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 4);
        send_frame(8'hA5, 1'b1, 8);
        check8("after_reset_data", data, 8'hA5);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_wr: %0d expected bytes never strobed", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_rx
`default_nettype wire
